sfft_window_buffer: RTL
=======================

Name: sfft_window_buffer

Overview:
- Parametrised front end for the SFFT pipeline.
- Captures one audio sample per rising edge of advanceSignal into a circular NFFT-deep window.
- Every HOP samples, once the window is full, streams the NFFT most recent samples to the FFT stages as a framed valid/ready burst.
- Burst order is natural or bit-reversed, selected by parameter; the previous sample buffer had neither overlap control, framing, ordering nor backpressure.

Parameters:
SAMPLE_WIDTH, 24, bits per sample (matches SFFT input width)
LOG2_NFFT, 5, window depth NFFT = 2^LOG2_NFFT
HOP, 16, new samples between frame starts; legal range 1..NFFT
BIT_REVERSE, 1, 1 = emit in bit-reversed index order, 0 = natural order

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
SampleAmplitudeIn  input  SAMPLE_WIDTH  sample value; stable from advanceSignal rise for at least 4 clk
advanceSignal  input  1  sample strobe from codec side; asynchronous to clk
out_data  output  SAMPLE_WIDTH  sample for current beat
out_index  output  LOG2_NFFT  beat number 0..NFFT-1 within frame
out_valid  output  1  beat valid
out_last  output  1  high on beat NFFT-1
out_ready  input  1  downstream accepts beat
frame_count  output  16  frames fully emitted; wraps 0xFFFF->0
overrun  output  1  sticky; a sample was dropped

Behaviour:
- Reset (reset_n low at a clk edge), taking effect that edge:
  - out_valid=0, out_last=0, out_index=0, out_data=0, frame_count=0, overrun=0.
  - Fill count, write pointer, hop count and skid register are cleared; state is FILL.
  - Buffer contents are not reset; the fill count prevents stale data from being emitted.
  - Reset mid-frame aborts the frame and does not increment frame_count.
- Strobe capture:
  - advanceSignal passes through a 2-flop synchroniser, then a rising-edge detector.
  - On the detect cycle, SampleAmplitudeIn is sampled. That is 3 clk after the rise at worst.
  - advanceSignal held high produces exactly one sample.
- Commit:
  - Outside EMIT, a sampled value is written to buf[wp] and wp increments mod NFFT.
  - Fill count saturates at NFFT. Hop count increments.
- States:
  - FILL -> EMIT on the commit that makes fill == NFFT.
  - ARMED -> EMIT on the commit that makes hop == HOP.
  - EMIT -> ARMED after the accepted last beat, or -> EMIT directly if the skid commit at that point completes a hop.
  - On every entry to EMIT: base = wp after the commit (the oldest sample), hop count = 0.
- Emission:
  - out_valid rises the clk after the triggering commit.
  - Beat k: out_index = k; out_data = buf[(base + r(k)) mod NFFT], where r(k) = bit-reverse of k over LOG2_NFFT bits if BIT_REVERSE=1, else r(k) = k.
  - A beat advances only on out_valid && out_ready, one beat per clk at most.
  - While out_valid && !out_ready, out_data, out_index and out_last hold stable.
  - On acceptance of beat NFFT-1: frame_count increments and out_valid drops the next clk, unless an immediate re-trigger occurs, in which case beat 0 of the next frame is presented next clk.
- Skid during EMIT:
  - A sample arriving during EMIT is held in a 1-entry skid register; the buffer is untouched, so frame integrity is guaranteed.
  - The skid commits on the clk after the last beat is accepted.
  - A sample arriving while the skid is full is dropped and overrun is set; the skid keeps the older sample.
- Simultaneous events:
  - Strobe detect on the same clk as last-beat acceptance goes to the skid and commits next clk.
  - Reset wins over everything.
- HOP = NFFT gives non-overlapping frames. HOP = 1 gives a frame per sample and relies on the sample period exceeding NFFT clks.

Test Plan:
1. Reset, BIT_REVERSE=0, HOP=16, out_ready=1, samples 1..32 spaced 100 clk -> one frame: out_data 1..32, out_index 0..31, out_last only at index 31, frame_count=1; no out_valid before the 32nd commit.
2. Continue with samples 33..48 -> second frame 17..48, frame_count=2; samples 33..47 produce no frame.
3. BIT_REVERSE=1, samples 1..32 -> beat order 1,17,9,25,5,21,13,29,3,...,32; out_index still 0..31.
4. Backpressure: out_ready low at beat 10 for 3000 clk, sample 49 arrives -> beat 10 data stable throughout; frame unchanged; 49 committed after last beat. A further sample 50 during the stall -> dropped, overrun=1 and stays 1.
5. advanceSignal held high 500 clk -> exactly one commit. Two rises 5 clk apart -> two commits.
6. reset_n low 1 clk at beat 10 -> out_valid=0, frame_count=0 next clk; no out_valid until 32 fresh samples are committed.

Source files
------------

// File: rtl/sfft_window_buffer_if.sv
// Framed valid/ready beat stream from the SFFT window buffer to the FFT stages.
// The master drives the beats and the slave returns out_ready.
interface sfft_window_buffer_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LOG2_NFFT    = 5
);
  logic [SAMPLE_WIDTH-1:0] out_data;
  logic [LOG2_NFFT-1:0]    out_index;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;

  modport master (output out_data, out_index, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_index, out_valid, out_last, output out_ready);
endinterface

// File: rtl/sfft_window_buffer.sv
// Circular NFFT-deep sample window for the SFFT front end. Every HOP samples it
// streams the NFFT most recent samples as one framed burst, in natural or bit-reversed order.
module sfft_window_buffer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LOG2_NFFT    = 5,
  parameter int HOP          = 16,
  parameter int BIT_REVERSE  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] SampleAmplitudeIn,
  input  logic                    advanceSignal,
  sfft_window_buffer_if.master    strm,
  output logic [15:0]             frame_count,
  output logic                    overrun
);
  localparam int NFFT = 1 << LOG2_NFFT;
  localparam int CW   = LOG2_NFFT + 1;

  typedef logic [LOG2_NFFT-1:0] idx_t;
  typedef logic [CW-1:0]        cnt_t;
  typedef enum logic [1:0] {FILL, ARMED, EMIT} state_t;

  localparam cnt_t NFFT_C   = cnt_t'(NFFT);
  localparam cnt_t HOP_C    = cnt_t'(HOP);
  localparam idx_t LAST_IDX = idx_t'(NFFT - 1);

  state_t state, state_nx;

  logic [SAMPLE_WIDTH-1:0] mem [NFFT];
  logic [SAMPLE_WIDTH-1:0] skid_data, commit_data;
  idx_t                    wp, base, beat, rd_addr;
  cnt_t                    fill, hop, fill_after, hop_after;
  logic                    adv_s1, adv_s2, adv_s3, skid_full;
  logic                    detect, emitting, accept, last_acc;
  logic                    skid_commit, in_commit, commit, to_skid, trig;

  function automatic idx_t bitrev(input idx_t v);
    idx_t r;
    for (int i = 0; i < LOG2_NFFT; i++) r[i] = v[LOG2_NFFT-1-i];
    return r;
  endfunction

  assign detect   = adv_s2 & ~adv_s3;
  assign emitting = (state == EMIT);
  assign accept   = emitting & strm.out_ready;
  assign last_acc = accept & (beat == LAST_IDX);

  // The skid drains on the last-beat acceptance edge, or at once if it is full outside EMIT;
  // a strobe that coincides with a drain takes the freed skid slot.
  assign skid_commit = skid_full & (~emitting | last_acc);
  assign in_commit   = detect & ~emitting & ~skid_full;
  assign commit      = skid_commit | in_commit;
  assign to_skid     = detect & (emitting | skid_full);
  assign commit_data = skid_commit ? skid_data : SampleAmplitudeIn;

  assign fill_after = (fill == NFFT_C) ? fill : fill + cnt_t'(1);
  assign hop_after  = hop + cnt_t'(1);
  assign trig       = commit & ((state == FILL) ? (fill_after == NFFT_C) : (hop_after == HOP_C));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= FILL;
    else          state <= state_nx;
  end

  always_comb begin
    // NOTE: default first, so no path through this block can infer a latch.
    state_nx = state;
    case (state)
      FILL:    if (trig) state_nx = EMIT;
      ARMED:   if (trig) state_nx = EMIT;
      EMIT:    if (last_acc) state_nx = trig ? EMIT : ARMED;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      adv_s1      <= 1'b0;
      adv_s2      <= 1'b0;
      adv_s3      <= 1'b0;
      wp          <= '0;
      base        <= '0;
      beat        <= '0;
      fill        <= '0;
      hop         <= '0;
      skid_full   <= 1'b0;
      skid_data   <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      adv_s1 <= advanceSignal;
      adv_s2 <= adv_s1;
      adv_s3 <= adv_s2;

      if (commit) begin
        wp   <= wp + idx_t'(1);
        fill <= fill_after;
        hop  <= hop_after;
      end

      // Base is the post-commit write pointer, i.e. the oldest sample in the window.
      if (trig) begin
        base <= wp + idx_t'(1);
        hop  <= '0;
        beat <= '0;
      end else if (accept) begin
        beat <= beat + idx_t'(1);
      end

      if (to_skid) begin
        if (skid_full && !skid_commit) begin
          overrun <= 1'b1;
        end else begin
          skid_data <= SampleAmplitudeIn;
          skid_full <= 1'b1;
        end
      end else if (skid_commit) begin
        skid_full <= 1'b0;
      end

      if (last_acc) frame_count <= frame_count + 16'd1;
    end
  end

  // NOTE: the sample store has no reset; the fill count keeps stale entries from being emitted.
  always_ff @(posedge clk) begin
    if (commit) mem[wp] <= commit_data;
  end

  assign rd_addr = base + ((BIT_REVERSE != 0) ? bitrev(beat) : beat);

  always_comb begin
    strm.out_valid = emitting;
    strm.out_index = beat;
    strm.out_last  = emitting && (beat == LAST_IDX);
    strm.out_data  = emitting ? mem[rd_addr] : '0;
  end
endmodule
